imem_bridge: RTL and testbench
==============================

Name: imem_bridge

Overview:
- Instruction-memory bridge directly upstream of the fetch stage.
- Accepts a 30-bit word-address request from fetch (ins_req/addr) and performs two sequential 16-bit reads on the breadboard instruction memory bus: low halfword first, then high halfword.
- Returns the assembled 32-bit word on data with a one-cycle ins_res pulse.
- Fixed wait-state counting plus a mem_ready qualifier accommodate slow SRAM/ROM.

Parameters:
- WAIT_CYCLES, 2: minimum cycles mem_rd is held per halfword before mem_rdata may be sampled; legal range 1..15.

Ports:
- cpu_clk  in  1  single system clock; all state updates on its rising edge.
- cpu_rst  in  1  reset, asynchronous, active-high.
- ins_req  in  1  fetch requests a word; level signal, sampled only in IDLE.
- addr  in  30  word address from fetch; sampled only in the same cycle as ins_req acceptance.
- ins_res  out  1  one-cycle pulse: data holds the requested word.
- data  out  32  {high halfword, low halfword}; registered, holds its value until the next response.
- busy  out  1  high in every state except IDLE.
- mem_addr  out  31  halfword address to memory.
- mem_rd  out  1  memory read strobe.
- mem_rdata  in  16  memory read data.
- mem_ready  in  1  memory data valid; tie high for fixed-latency parts.

Behaviour:
- Reset (async, any state): state=IDLE, ins_res=0, data=0, mem_addr=0, mem_rd=0, busy=0, wait counter=0, latched address=0.
- State IDLE:
  - If ins_req=1, latch addr at the edge, then go to RD_LO.
  - Otherwise stay.
  - mem_rd=0.
- State RD_LO:
  - mem_addr={addr_q,1'b0}, mem_rd=1.
  - Wait counter starts at 0 on entry and increments each cycle, saturating at WAIT_CYCLES-1.
  - When counter==WAIT_CYCLES-1 and mem_ready=1: capture mem_rdata into the low half, reset counter, go to RD_HI.
  - mem_ready=0 at terminal count: hold in RD_LO with mem_rd and mem_addr stable, indefinitely.
- State RD_HI:
  - mem_addr={addr_q,1'b1}, mem_rd=1.
  - Same counting and ready rule as RD_LO.
  - On capture: load data={mem_rdata, low_q} at that edge, go to RESP.
- State RESP:
  - ins_res=1 for exactly this one cycle, mem_rd=0, then unconditionally return to IDLE.
  - addr is never sampled in RESP, because fetch advances its address on the edge that ends RESP.
  - Earliest next acceptance is the IDLE cycle after RESP.
- Latency with mem_ready tied high: 2*WAIT_CYCLES+1 cycles from the accepting edge to the ins_res cycle.
  - WAIT_CYCLES=2: ins_res high in the 5th cycle after acceptance.
  - Back-to-back throughput: one word per 2*WAIT_CYCLES+2 cycles.
- ins_req deassertion mid-transaction: no effect; the transaction completes and ins_res still pulses. Fetch discards unwanted responses itself.
- Changes on addr mid-transaction: ignored (latched copy used).
- Address arithmetic:
  - mem_addr is a plain concatenation, no adder; addr=30'h3FFFFFFF yields 31'h7FFFFFFE then 31'h7FFFFFFF.
  - No wrap logic needed.
- mem_rd is deasserted in IDLE and RESP.
- mem_rd stays continuously high across the RD_LO to RD_HI transition; only mem_addr changes.
- busy is combinational from state only.
- No X propagation: data updates only on RD_HI capture.

Test Plan:
- WAIT_CYCLES=2, mem_ready=1, addr=30'h5, memory returns 16'h1234 at 31'hA and 16'hABCD at 31'hB:
  - mem_addr shows 31'hA for 2 cycles, then 31'hB for 2 cycles.
  - data=32'hABCD1234 with ins_res high exactly in cycle 5 after acceptance, then low.
- ins_req held high continuously, addr=30'h10 then 30'h11 (changed on the ins_res edge):
  - Second acceptance occurs in the IDLE cycle after RESP and latches 30'h11.
  - No cycle accepts a stale address.
  - ins_res pulses are 6 cycles apart.
- mem_ready held low for 3 extra cycles during RD_HI:
  - mem_addr and mem_rd stay stable.
  - ins_res is delayed by exactly 3 cycles.
  - data is still correct.
- ins_req dropped one cycle after acceptance, addr toggled randomly:
  - Full transaction still runs on the latched address.
  - A single ins_res pulse is produced.
- cpu_rst asserted asynchronously mid-RD_HI (between clock edges):
  - mem_rd, busy and ins_res drop immediately, and data=0.
  - After release with ins_req=1, a fresh transaction starts from RD_LO.
- addr=30'h3FFFFFFF:
  - mem_addr=31'h7FFFFFFE then 31'h7FFFFFFF.
  - data assembled correctly.

Source files
------------

// File: rtl/imem_bridge_if.sv
// Fetch-side and memory-side signals of the instruction-memory bridge.
// The bridge uses the slave view; fetch plus the memory model use master.
interface imem_bridge_if;
  logic        ins_req;
  logic [29:0] addr;
  logic        ins_res;
  logic [31:0] data;
  logic        busy;
  logic [30:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  ins_req, addr, mem_rdata, mem_ready,
    output ins_res, data, busy, mem_addr, mem_rd
  );

  modport master (
    output ins_req, addr, mem_rdata, mem_ready,
    input  ins_res, data, busy, mem_addr, mem_rd
  );
endinterface

// File: rtl/imem_bridge.sv
// Instruction-memory bridge: turns one 32-bit word fetch into two 16-bit
// reads (low halfword, then high halfword) on the instruction memory bus,
// each held for WAIT_CYCLES cycles and qualified by mem_ready.
module imem_bridge #(
  parameter int unsigned WAIT_CYCLES = 2  // legal range 1..15
) (
  input  logic          cpu_clk,
  input  logic          cpu_rst,
  imem_bridge_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [29:0] addr_q;
  logic [15:0] low_q;
  logic [31:0] data_q;

  logic reading;
  logic term;
  logic capture;

  // A halfword is taken only once the minimum hold time has elapsed and
  // memory says the data is valid.
  assign reading = (state_q == RD_LO) || (state_q == RD_HI);
  assign term    = (cnt_q == LAST);
  assign capture = reading && term && bus.mem_ready;

  // State register.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (cpu_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so no path through this block leaves state_d
    // unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.ins_req) state_d = RD_LO;
      RD_LO:   if (capture)     state_d = RD_HI;
      RD_HI:   if (capture)     state_d = RESP;
      RESP:                     state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Wait-state counter: zero outside the read states, counts up and
  // saturates at the terminal value, restarts for the next halfword.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      cnt_q <= '0;
    end else if (!reading) begin
      cnt_q <= '0;
    end else if (term) begin
      if (bus.mem_ready) cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  // Address latch: fetch may move addr once accepted, so the bridge works
  // from its own copy for the whole transaction.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst)                         addr_q <= '0;
    else if (state_q == IDLE && bus.ins_req) addr_q <= bus.addr;
  end

  // Halfword capture: low half parked until the high half arrives, then the
  // whole word is loaded at once so data never shows a half-updated value.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      low_q  <= '0;
      data_q <= '0;
    end else if (capture) begin
      if (state_q == RD_LO) low_q  <= bus.mem_rdata;
      else                  data_q <= {bus.mem_rdata, low_q};
    end
  end

  // Outputs decode from state only, so an asynchronous reset clears the
  // strobes immediately. mem_rd stays high across RD_LO -> RD_HI; only the
  // halfword select bit of mem_addr changes.
  assign bus.busy     = (state_q != IDLE);
  assign bus.ins_res  = (state_q == RESP);
  assign bus.mem_rd   = reading;
  assign bus.mem_addr = {addr_q, (state_q == RD_HI)};
  assign bus.data     = data_q;

endmodule

// File: tb/tb_imem_bridge.sv
// Directed bench for imem_bridge: expected words are queued when a request
// is driven and compared whenever the bridge pulses ins_res.
module tb_imem_bridge;

  localparam int unsigned W = 2;

  logic cpu_clk = 1'b0;
  logic cpu_rst;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb[$];

  imem_bridge_if bus();

  imem_bridge #(.WAIT_CYCLES(W)) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus.slave)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Memory contents: two fixed words for the basic case, a scrambled
  // function of the address everywhere else.
  function automatic logic [15:0] mem_fn(input logic [30:0] a);
    if (a == 31'hA) return 16'h1234;
    if (a == 31'hB) return 16'hABCD;
    return a[15:0] ^ {1'b0, a[30:16]} ^ 16'h5A3C;
  endfunction

  function automatic logic [31:0] exp_word(input logic [29:0] a);
    return {mem_fn({a, 1'b1}), mem_fn({a, 1'b0})};
  endfunction

  assign bus.mem_rdata = bus.mem_rd ? mem_fn(bus.mem_addr) : 16'h0000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts negedges until ins_res is seen; budget+1 means it never came.
  task automatic wait_res(input int budget, output int n);
    for (n = 1; n <= budget; n++) begin
      @(negedge cpu_clk);
      if (bus.ins_res === 1'b1) break;
    end
  endtask

  // Scoreboard: every response must match the oldest outstanding request.
  always @(negedge cpu_clk) begin
    if (bus.ins_res === 1'b1) begin
      if (sb.size() == 0) check("unexpected_res", 64'd1, 64'd0);
      else                check("res_data", bus.data, sb.pop_front());
    end
  end

  initial begin
    int n;
    int pulses;

    cpu_rst       = 1'b1;
    bus.ins_req   = 1'b0;
    bus.addr      = '0;
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge cpu_clk);

    // Reset state
    check("rst_busy",     bus.busy,     0);
    check("rst_ins_res",  bus.ins_res,  0);
    check("rst_mem_rd",   bus.mem_rd,   0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_data",     bus.data,     0);
    cpu_rst = 1'b0;
    @(negedge cpu_clk);

    // Basic read, addr 5 -> halfwords at 0xA / 0xB
    bus.ins_req = 1'b1;
    bus.addr    = 30'h5;
    sb.push_back(exp_word(30'h5));
    for (int c = 1; c <= 6; c++) begin
      @(negedge cpu_clk);
      if (c == 1) bus.ins_req = 1'b0;
      check("t1_ins_res", bus.ins_res, 64'(c == 5));
      check("t1_busy",    bus.busy,    64'(c <= 5));
      check("t1_mem_rd",  bus.mem_rd,  64'(c <= 4));
      if (c <= 4) check("t1_mem_addr", bus.mem_addr, (c <= 2) ? 31'hA : 31'hB);
      if (c >= 5) check("t1_data", bus.data, 32'hABCD1234);
    end

    // Back-to-back with ins_req held high; addr advances on the RESP edge
    bus.ins_req = 1'b1;
    bus.addr    = 30'h10;
    sb.push_back(exp_word(30'h10));
    wait_res(20, n);
    check("t2_latency", n, 5);
    bus.addr = 30'h11;
    sb.push_back(exp_word(30'h11));
    @(negedge cpu_clk);
    check("t2_idle_gap", bus.busy, 0);
    wait_res(20, n);
    check("t2_spacing", n + 1, 6);
    bus.ins_req = 1'b0;

    // mem_ready low for 3 extra cycles during RD_HI
    @(negedge cpu_clk);
    bus.ins_req = 1'b1;
    bus.addr    = 30'h20;
    sb.push_back(exp_word(30'h20));
    for (int c = 1; c <= 8; c++) begin
      @(negedge cpu_clk);
      if (c == 1) bus.ins_req = 1'b0;
      check("t3_ins_res", bus.ins_res, 64'(c == 8));
      if (c >= 3 && c <= 7) begin
        check("t3_mem_addr", bus.mem_addr, 31'h41);
        check("t3_mem_rd",   bus.mem_rd,   1);
      end
      if (c == 3) bus.mem_ready = 1'b0;
      if (c == 7) bus.mem_ready = 1'b1;
    end

    // ins_req dropped after acceptance, addr scrambled mid-transaction
    @(negedge cpu_clk);
    bus.ins_req = 1'b1;
    bus.addr    = 30'h1234567;
    sb.push_back(exp_word(30'h1234567));
    pulses = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge cpu_clk);
      if (c == 1) bus.ins_req = 1'b0;
      if (bus.ins_res === 1'b1) pulses++;
      if (c == 1) check("t4_addr_lo", bus.mem_addr, {30'h1234567, 1'b0});
      if (c == 3) check("t4_addr_hi", bus.mem_addr, {30'h1234567, 1'b1});
      check("t4_ins_res", bus.ins_res, 64'(c == 5));
      bus.addr = 30'($urandom);
    end
    check("t4_pulses", pulses, 1);

    // Asynchronous reset in the middle of RD_HI
    bus.ins_req = 1'b1;
    bus.addr    = 30'h77;
    repeat (3) @(negedge cpu_clk);
    check("t5_in_rd_hi", bus.mem_addr, {30'h77, 1'b1});
    #2 cpu_rst = 1'b1;
    #1;
    check("t5_rst_mem_rd",  bus.mem_rd,  0);
    check("t5_rst_busy",    bus.busy,    0);
    check("t5_rst_ins_res", bus.ins_res, 0);
    check("t5_rst_data",    bus.data,    0);
    bus.addr = 30'h99;
    sb.push_back(exp_word(30'h99));
    cpu_rst = 1'b0;
    @(negedge cpu_clk);
    check("t5_fresh_addr", bus.mem_addr, {30'h99, 1'b0});
    check("t5_fresh_rd",   bus.mem_rd,   1);
    bus.ins_req = 1'b0;
    wait_res(20, n);
    check("t5_latency", n, 4);

    // Top-of-range address: plain concatenation, no wrap
    @(negedge cpu_clk);
    bus.ins_req = 1'b1;
    bus.addr    = 30'h3FFFFFFF;
    sb.push_back(exp_word(30'h3FFFFFFF));
    @(negedge cpu_clk);
    bus.ins_req = 1'b0;
    check("t6_addr_lo", bus.mem_addr, 31'h7FFFFFFE);
    repeat (2) @(negedge cpu_clk);
    check("t6_addr_hi", bus.mem_addr, 31'h7FFFFFFF);
    wait_res(20, n);
    check("t6_latency", n, 2);
    check("t6_data", bus.data, exp_word(30'h3FFFFFFF));

    @(negedge cpu_clk);
    check("sb_drained", 64'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
